// File: rtl/axi4_dram_arbiter.sv
// axi4_dram_arbiter: shares one AXI4 memory port between two masters.
// AR/AW are round-robin arbitrated, W follows AW grant order, and R/B route back by the ID MSB.

module axi4_dram_arb_stage #(
    parameter int PW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [PW-1:0] req0_pld,
    input  logic          req1_valid,
    input  logic [PW-1:0] req1_pld,
    input  logic          grant_ok,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pld,
    output logic          out_src
);

    logic          valid_q, valid_d;
    logic [PW-1:0] pld_q, pld_d;
    logic          last_q, last_d;
    logic          load_en;
    logic          winner;
    logic          win_valid;
    logic          gate;
    logic          take;

    // Pick the winner, drive master readies, and compute the next output register
    always_comb begin
        load_en = !valid_q || out_ready;
        if (req0_valid && req1_valid) begin
            winner = !last_q;
        end else begin
            winner = req1_valid;
        end
        gate       = load_en && grant_ok && !reset;
        req0_ready = gate && !winner;
        req1_ready = gate && winner;
        win_valid  = winner ? req1_valid : req0_valid;
        take       = gate && win_valid;
        valid_d    = valid_q;
        pld_d      = pld_q;
        last_d     = last_q;
        if (load_en) begin
            valid_d = take;
        end
        if (take) begin
            pld_d  = winner ? req1_pld : req0_pld;
            last_d = winner;
        end
        if (reset) begin
            valid_d = 1'b0;
            pld_d   = '0;
            last_d  = 1'b1;
        end
    end

    // Output register and last-grant pointer
    always_ff @(posedge clock) begin
        valid_q <= valid_d;
        pld_q   <= pld_d;
        last_q  <= last_d;
    end

    // The last-grant pointer is also the source of the registered beat
    assign out_valid = valid_q;
    assign out_pld   = pld_q;
    assign out_src   = last_q;

endmodule

module axi4_dram_arbiter #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int ID_BITS      = 4,
    parameter int W_FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   m0_ar_valid,
    output logic                   m0_ar_ready,
    input  logic [ADDR_BITS-1:0]   m0_ar_addr,
    input  logic [7:0]             m0_ar_len,
    input  logic [2:0]             m0_ar_size,
    input  logic [ID_BITS-1:0]     m0_ar_id,
    input  logic                   m0_aw_valid,
    output logic                   m0_aw_ready,
    input  logic [ADDR_BITS-1:0]   m0_aw_addr,
    input  logic [7:0]             m0_aw_len,
    input  logic [2:0]             m0_aw_size,
    input  logic [ID_BITS-1:0]     m0_aw_id,
    input  logic                   m0_w_valid,
    output logic                   m0_w_ready,
    input  logic [DATA_BITS-1:0]   m0_w_data,
    input  logic [DATA_BITS/8-1:0] m0_w_strb,
    input  logic                   m0_w_last,
    output logic                   m0_r_valid,
    input  logic                   m0_r_ready,
    output logic [ID_BITS-1:0]     m0_r_id,
    output logic [1:0]             m0_r_resp,
    output logic [DATA_BITS-1:0]   m0_r_data,
    output logic                   m0_r_last,
    output logic                   m0_b_valid,
    input  logic                   m0_b_ready,
    output logic [ID_BITS-1:0]     m0_b_id,
    output logic [1:0]             m0_b_resp,

    input  logic                   m1_ar_valid,
    output logic                   m1_ar_ready,
    input  logic [ADDR_BITS-1:0]   m1_ar_addr,
    input  logic [7:0]             m1_ar_len,
    input  logic [2:0]             m1_ar_size,
    input  logic [ID_BITS-1:0]     m1_ar_id,
    input  logic                   m1_aw_valid,
    output logic                   m1_aw_ready,
    input  logic [ADDR_BITS-1:0]   m1_aw_addr,
    input  logic [7:0]             m1_aw_len,
    input  logic [2:0]             m1_aw_size,
    input  logic [ID_BITS-1:0]     m1_aw_id,
    input  logic                   m1_w_valid,
    output logic                   m1_w_ready,
    input  logic [DATA_BITS-1:0]   m1_w_data,
    input  logic [DATA_BITS/8-1:0] m1_w_strb,
    input  logic                   m1_w_last,
    output logic                   m1_r_valid,
    input  logic                   m1_r_ready,
    output logic [ID_BITS-1:0]     m1_r_id,
    output logic [1:0]             m1_r_resp,
    output logic [DATA_BITS-1:0]   m1_r_data,
    output logic                   m1_r_last,
    output logic                   m1_b_valid,
    input  logic                   m1_b_ready,
    output logic [ID_BITS-1:0]     m1_b_id,
    output logic [1:0]             m1_b_resp,

    output logic                   s_ar_valid,
    input  logic                   s_ar_ready,
    output logic [ADDR_BITS-1:0]   s_ar_addr,
    output logic [7:0]             s_ar_len,
    output logic [2:0]             s_ar_size,
    output logic [ID_BITS:0]       s_ar_id,
    output logic [1:0]             s_ar_burst,
    output logic                   s_ar_lock,
    output logic [3:0]             s_ar_cache,
    output logic [2:0]             s_ar_prot,
    output logic [3:0]             s_ar_qos,
    output logic                   s_aw_valid,
    input  logic                   s_aw_ready,
    output logic [ADDR_BITS-1:0]   s_aw_addr,
    output logic [7:0]             s_aw_len,
    output logic [2:0]             s_aw_size,
    output logic [ID_BITS:0]       s_aw_id,
    output logic [1:0]             s_aw_burst,
    output logic                   s_aw_lock,
    output logic [3:0]             s_aw_cache,
    output logic [2:0]             s_aw_prot,
    output logic [3:0]             s_aw_qos,
    output logic                   s_w_valid,
    input  logic                   s_w_ready,
    output logic [DATA_BITS-1:0]   s_w_data,
    output logic [DATA_BITS/8-1:0] s_w_strb,
    output logic                   s_w_last,
    input  logic                   s_r_valid,
    output logic                   s_r_ready,
    input  logic [ID_BITS:0]       s_r_id,
    input  logic [1:0]             s_r_resp,
    input  logic [DATA_BITS-1:0]   s_r_data,
    input  logic                   s_r_last,
    input  logic                   s_b_valid,
    output logic                   s_b_ready,
    input  logic [ID_BITS:0]       s_b_id,
    input  logic [1:0]             s_b_resp
);

    localparam int PW = ADDR_BITS + 8 + 3 + ID_BITS;
    localparam int QW = $clog2(W_FIFO_DEPTH);

    logic [PW-1:0]      ar_pld;
    logic [PW-1:0]      aw_pld;
    logic               ar_src;
    logic               aw_src;
    logic [ID_BITS-1:0] ar_id_lo;
    logic [ID_BITS-1:0] aw_id_lo;

    logic [W_FIFO_DEPTH-1:0] src_q, src_d;
    logic [QW-1:0]           rd_q, rd_d;
    logic [QW-1:0]           wr_q, wr_d;
    logic [QW:0]             cnt_q, cnt_d;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head;
    logic                    w_act;
    logic                    aw_push;
    logic                    aw_push_src;
    logic                    w_pop;

    axi4_dram_arb_stage #(.PW(PW)) u_ar (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (m0_ar_valid),
        .req0_pld   ({m0_ar_addr, m0_ar_len, m0_ar_size, m0_ar_id}),
        .req1_valid (m1_ar_valid),
        .req1_pld   ({m1_ar_addr, m1_ar_len, m1_ar_size, m1_ar_id}),
        .grant_ok   (1'b1),
        .req0_ready (m0_ar_ready),
        .req1_ready (m1_ar_ready),
        .out_valid  (s_ar_valid),
        .out_ready  (s_ar_ready),
        .out_pld    (ar_pld),
        .out_src    (ar_src)
    );

    axi4_dram_arb_stage #(.PW(PW)) u_aw (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (m0_aw_valid),
        .req0_pld   ({m0_aw_addr, m0_aw_len, m0_aw_size, m0_aw_id}),
        .req1_valid (m1_aw_valid),
        .req1_pld   ({m1_aw_addr, m1_aw_len, m1_aw_size, m1_aw_id}),
        .grant_ok   (!fifo_full),
        .req0_ready (m0_aw_ready),
        .req1_ready (m1_aw_ready),
        .out_valid  (s_aw_valid),
        .out_ready  (s_aw_ready),
        .out_pld    (aw_pld),
        .out_src    (aw_src)
    );

    assign {s_ar_addr, s_ar_len, s_ar_size, ar_id_lo} = ar_pld;
    assign {s_aw_addr, s_aw_len, s_aw_size, aw_id_lo} = aw_pld;
    assign s_ar_id    = {ar_src, ar_id_lo};
    assign s_aw_id    = {aw_src, aw_id_lo};
    assign s_ar_burst = 2'b01;
    assign s_ar_lock  = 1'b0;
    assign s_ar_cache = 4'b0;
    assign s_ar_prot  = 3'b0;
    assign s_ar_qos   = 4'b0;
    assign s_aw_burst = 2'b01;
    assign s_aw_lock  = 1'b0;
    assign s_aw_cache = 4'b0;
    assign s_aw_prot  = 3'b0;
    assign s_aw_qos   = 4'b0;

    // Steer W from the master at the head of the grant-order FIFO
    always_comb begin
        fifo_full   = cnt_q == (QW+1)'(W_FIFO_DEPTH);
        fifo_empty  = cnt_q == '0;
        head        = src_q[rd_q];
        w_act       = !fifo_empty && !reset;
        s_w_valid   = w_act && (head ? m1_w_valid : m0_w_valid);
        s_w_data    = head ? m1_w_data : m0_w_data;
        s_w_strb    = head ? m1_w_strb : m0_w_strb;
        s_w_last    = head ? m1_w_last : m0_w_last;
        m0_w_ready  = w_act && !head && s_w_ready;
        m1_w_ready  = w_act && head && s_w_ready;
        w_pop       = s_w_valid && s_w_ready && s_w_last;
        aw_push     = (m0_aw_valid && m0_aw_ready) ||
                      (m1_aw_valid && m1_aw_ready);
        aw_push_src = m1_aw_valid && m1_aw_ready;
    end

    // Next state of the grant-order FIFO; a full FIFO never sees a push
    always_comb begin
        src_d = src_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (aw_push) begin
            src_d[wr_q] = aw_push_src;
            wr_d        = wr_q + QW'(1);
        end
        if (w_pop) begin
            rd_d = rd_q + QW'(1);
        end
        if (aw_push && !w_pop) begin
            cnt_d = cnt_q + (QW+1)'(1);
        end else if (!aw_push && w_pop) begin
            cnt_d = cnt_q - (QW+1)'(1);
        end
        if (reset) begin
            src_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Grant-order FIFO registers
    always_ff @(posedge clock) begin
        src_q <= src_d;
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
    end

    // Route R and B back by the ID MSB
    always_comb begin
        m0_r_valid = s_r_valid && !s_r_id[ID_BITS];
        m1_r_valid = s_r_valid && s_r_id[ID_BITS];
        s_r_ready  = s_r_id[ID_BITS] ? m1_r_ready : m0_r_ready;
        m0_r_id    = s_r_id[ID_BITS-1:0];
        m1_r_id    = s_r_id[ID_BITS-1:0];
        m0_r_resp  = s_r_resp;
        m1_r_resp  = s_r_resp;
        m0_r_data  = s_r_data;
        m1_r_data  = s_r_data;
        m0_r_last  = s_r_last;
        m1_r_last  = s_r_last;
        m0_b_valid = s_b_valid && !s_b_id[ID_BITS];
        m1_b_valid = s_b_valid && s_b_id[ID_BITS];
        s_b_ready  = s_b_id[ID_BITS] ? m1_b_ready : m0_b_ready;
        m0_b_id    = s_b_id[ID_BITS-1:0];
        m1_b_id    = s_b_id[ID_BITS-1:0];
        m0_b_resp  = s_b_resp;
        m1_b_resp  = s_b_resp;
    end

endmodule

// File: tb/tb_axi4_dram_arbiter.sv
// tb_axi4_dram_arbiter: directed checks of arbitration, W steering,
// response routing, FIFO full, downstream stall and reset.
module tb_axi4_dram_arbiter;

    logic        clock;
    logic        reset;

    logic        m0_ar_valid, m0_ar_ready;
    logic [31:0] m0_ar_addr;
    logic [7:0]  m0_ar_len;
    logic [2:0]  m0_ar_size;
    logic [3:0]  m0_ar_id;
    logic        m0_aw_valid, m0_aw_ready;
    logic [31:0] m0_aw_addr;
    logic [7:0]  m0_aw_len;
    logic [2:0]  m0_aw_size;
    logic [3:0]  m0_aw_id;
    logic        m0_w_valid, m0_w_ready;
    logic [63:0] m0_w_data;
    logic [7:0]  m0_w_strb;
    logic        m0_w_last;
    logic        m0_r_valid, m0_r_ready;
    logic [3:0]  m0_r_id;
    logic [1:0]  m0_r_resp;
    logic [63:0] m0_r_data;
    logic        m0_r_last;
    logic        m0_b_valid, m0_b_ready;
    logic [3:0]  m0_b_id;
    logic [1:0]  m0_b_resp;

    logic        m1_ar_valid, m1_ar_ready;
    logic [31:0] m1_ar_addr;
    logic [7:0]  m1_ar_len;
    logic [2:0]  m1_ar_size;
    logic [3:0]  m1_ar_id;
    logic        m1_aw_valid, m1_aw_ready;
    logic [31:0] m1_aw_addr;
    logic [7:0]  m1_aw_len;
    logic [2:0]  m1_aw_size;
    logic [3:0]  m1_aw_id;
    logic        m1_w_valid, m1_w_ready;
    logic [63:0] m1_w_data;
    logic [7:0]  m1_w_strb;
    logic        m1_w_last;
    logic        m1_r_valid, m1_r_ready;
    logic [3:0]  m1_r_id;
    logic [1:0]  m1_r_resp;
    logic [63:0] m1_r_data;
    logic        m1_r_last;
    logic        m1_b_valid, m1_b_ready;
    logic [3:0]  m1_b_id;
    logic [1:0]  m1_b_resp;

    logic        s_ar_valid, s_ar_ready;
    logic [31:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [2:0]  s_ar_size;
    logic [4:0]  s_ar_id;
    logic [1:0]  s_ar_burst;
    logic        s_ar_lock;
    logic [3:0]  s_ar_cache;
    logic [2:0]  s_ar_prot;
    logic [3:0]  s_ar_qos;
    logic        s_aw_valid, s_aw_ready;
    logic [31:0] s_aw_addr;
    logic [7:0]  s_aw_len;
    logic [2:0]  s_aw_size;
    logic [4:0]  s_aw_id;
    logic [1:0]  s_aw_burst;
    logic        s_aw_lock;
    logic [3:0]  s_aw_cache;
    logic [2:0]  s_aw_prot;
    logic [3:0]  s_aw_qos;
    logic        s_w_valid, s_w_ready;
    logic [63:0] s_w_data;
    logic [7:0]  s_w_strb;
    logic        s_w_last;
    logic        s_r_valid, s_r_ready;
    logic [4:0]  s_r_id;
    logic [1:0]  s_r_resp;
    logic [63:0] s_r_data;
    logic        s_r_last;
    logic        s_b_valid, s_b_ready;
    logic [4:0]  s_b_id;
    logic [1:0]  s_b_resp;

    int n_vec;
    int n_err;

    axi4_dram_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
        .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len),
        .m0_ar_size(m0_ar_size), .m0_ar_id(m0_ar_id),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
        .m0_aw_addr(m0_aw_addr), .m0_aw_len(m0_aw_len),
        .m0_aw_size(m0_aw_size), .m0_aw_id(m0_aw_id),
        .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
        .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb),
        .m0_w_last(m0_w_last),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
        .m0_r_id(m0_r_id), .m0_r_resp(m0_r_resp),
        .m0_r_data(m0_r_data), .m0_r_last(m0_r_last),
        .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
        .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
        .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len),
        .m1_ar_size(m1_ar_size), .m1_ar_id(m1_ar_id),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
        .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
        .m1_aw_size(m1_aw_size), .m1_aw_id(m1_aw_id),
        .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
        .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb),
        .m1_w_last(m1_w_last),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
        .m1_r_id(m1_r_id), .m1_r_resp(m1_r_resp),
        .m1_r_data(m1_r_data), .m1_r_last(m1_r_last),
        .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
        .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_id(s_ar_id),
        .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
        .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
        .s_ar_qos(s_ar_qos),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_id(s_aw_id),
        .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
        .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
        .s_aw_qos(s_aw_qos),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_id(s_r_id), .s_r_resp(s_r_resp),
        .s_r_data(s_r_data), .s_r_last(s_r_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        m0_ar_valid = 0; m0_ar_addr = 0; m0_ar_len = 0;
        m0_ar_size = 3; m0_ar_id = 0;
        m0_aw_valid = 0; m0_aw_addr = 0; m0_aw_len = 0;
        m0_aw_size = 3; m0_aw_id = 0;
        m0_w_valid = 0; m0_w_data = 0; m0_w_strb = 8'hFF; m0_w_last = 0;
        m0_r_ready = 0; m0_b_ready = 0;
        m1_ar_valid = 0; m1_ar_addr = 0; m1_ar_len = 0;
        m1_ar_size = 3; m1_ar_id = 0;
        m1_aw_valid = 0; m1_aw_addr = 0; m1_aw_len = 0;
        m1_aw_size = 3; m1_aw_id = 0;
        m1_w_valid = 0; m1_w_data = 0; m1_w_strb = 8'hFF; m1_w_last = 0;
        m1_r_ready = 0; m1_b_ready = 0;
        s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
        s_r_valid = 0; s_r_id = 0; s_r_resp = 0; s_r_data = 0; s_r_last = 0;
        s_b_valid = 0; s_b_id = 0; s_b_resp = 0;

        // reset state
        tick;
        m0_ar_valid = 1; m1_ar_valid = 1; m0_aw_valid = 1;
        s_ar_ready = 1; s_aw_ready = 1;
        #1;
        chk("rst_m0_ar_ready", m0_ar_ready, 0);
        chk("rst_m1_ar_ready", m1_ar_ready, 0);
        chk("rst_m0_aw_ready", m0_aw_ready, 0);
        tick;
        chk("rst_s_ar_valid", s_ar_valid, 0);
        chk("rst_s_aw_valid", s_aw_valid, 0);
        chk("rst_s_w_valid", s_w_valid, 0);
        chk("rst_m0_r_valid", m0_r_valid, 0);
        chk("rst_m1_b_valid", m1_b_valid, 0);
        m0_ar_valid = 0; m1_ar_valid = 0; m0_aw_valid = 0;
        reset = 0;

        // simultaneous AR
        m0_ar_valid = 1; m0_ar_id = 4'd5; m0_ar_addr = 32'h1000;
        m1_ar_valid = 1; m1_ar_id = 4'd9; m1_ar_addr = 32'h2000;
        m1_ar_len = 8'd7;
        #1;
        chk("ar1_m0_ready", m0_ar_ready, 1);
        chk("ar1_m1_ready", m1_ar_ready, 0);
        tick;
        m0_ar_valid = 0;
        #1;
        chk("ar2_s_valid", s_ar_valid, 1);
        chk("ar2_s_id", s_ar_id, 5'h05);
        chk("ar2_s_addr", s_ar_addr, 32'h1000);
        chk("ar2_s_burst", s_ar_burst, 2'b01);
        chk("ar2_s_cache", s_ar_cache, 0);
        chk("ar2_m1_ready", m1_ar_ready, 1);
        tick;
        m1_ar_valid = 0;
        #1;
        chk("ar3_s_id", s_ar_id, 5'h19);
        chk("ar3_s_addr", s_ar_addr, 32'h2000);
        chk("ar3_s_len", s_ar_len, 8'd7);
        tick;
        chk("ar4_s_valid", s_ar_valid, 0);

        // R routing and backpressure
        s_r_valid = 1; s_r_id = 5'h13; s_r_data = 64'hDEADBEEF;
        s_r_resp = 2'd2; s_r_last = 1;
        m1_r_ready = 0; m0_r_ready = 1;
        #1;
        chk("r_m1_valid", m1_r_valid, 1);
        chk("r_m1_id", m1_r_id, 4'd3);
        chk("r_m1_data", m1_r_data, 64'hDEADBEEF);
        chk("r_m1_resp", m1_r_resp, 2'd2);
        chk("r_m0_valid", m0_r_valid, 0);
        chk("r_s_ready_lo", s_r_ready, 0);
        m1_r_ready = 1;
        #1;
        chk("r_s_ready_hi", s_r_ready, 1);
        s_r_valid = 0;

        // B routing to m0
        s_b_valid = 1; s_b_id = 5'h07; s_b_resp = 2'd1;
        m0_b_ready = 1; m1_b_ready = 0;
        #1;
        chk("b_m0_valid", m0_b_valid, 1);
        chk("b_m0_id", m0_b_id, 4'd7);
        chk("b_m0_resp", m0_b_resp, 2'd1);
        chk("b_m1_valid", m1_b_valid, 0);
        chk("b_s_ready", s_b_ready, 1);
        s_b_valid = 0;
        tick;

        // W ordering
        s_aw_ready = 1; s_w_ready = 1;
        m1_aw_valid = 1; m1_aw_len = 8'd3; m1_aw_id = 4'd2;
        m1_aw_addr = 32'h3000;
        #1;
        chk("w_m1_aw_ready", m1_aw_ready, 1);
        tick;
        m1_aw_valid = 0;
        m0_aw_valid = 1; m0_aw_len = 8'd0; m0_aw_id = 4'd4;
        m0_aw_addr = 32'h4000;
        m0_w_valid = 1; m0_w_data = 64'hA0; m0_w_last = 1;
        #1;
        chk("w_s_aw_id_m1", s_aw_id, 5'h12);
        chk("w_m0_aw_ready", m0_aw_ready, 1);
        chk("w_m0_blocked", m0_w_ready, 0);
        chk("w_s_valid_wait", s_w_valid, 0);
        tick;
        m0_aw_valid = 0;
        for (int i = 0; i < 4; i++) begin
            m1_w_valid = 1;
            m1_w_data = 64'hB0 + 64'(i);
            m1_w_last = (i == 3);
            #1;
            chk("w_m1_ready", m1_w_ready, 1);
            chk("w_m1_data", s_w_data, 64'hB0 + 64'(i));
            chk("w_m0_held", m0_w_ready, 0);
            chk("w_last", s_w_last, (i == 3) ? 1 : 0);
            if (i == 0) chk("w_s_aw_id_m0", s_aw_id, 5'h04);
            tick;
        end
        m1_w_valid = 0; m1_w_last = 0;
        #1;
        chk("w_m0_valid", s_w_valid, 1);
        chk("w_m0_ready", m0_w_ready, 1);
        chk("w_m0_data", s_w_data, 64'hA0);
        chk("w_m0_last", s_w_last, 1);
        chk("w_m1_not_ready", m1_w_ready, 0);
        tick;
        chk("w_empty", s_w_valid, 0);
        chk("w_empty_ready", m0_w_ready, 0);
        m0_w_valid = 0;

        // FIFO full
        m0_aw_valid = 1; m0_aw_id = 4'd1; m0_aw_len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_aw_ready", m0_aw_ready, 1);
            tick;
        end
        chk("full_blocked", m0_aw_ready, 0);
        tick;
        chk("full_s_aw_valid", s_aw_valid, 0);
        chk("full_still_blocked", m0_aw_ready, 0);
        m0_w_valid = 1; m0_w_last = 1; m0_w_data = 64'hC0;
        #1;
        chk("full_w_ready", m0_w_ready, 1);
        chk("full_pop_no_push", m0_aw_ready, 0);
        tick;
        m0_w_valid = 0;
        #1;
        chk("full_reopen", m0_aw_ready, 1);
        tick;
        m0_aw_valid = 0;
        #1;
        chk("full_5th_valid", s_aw_valid, 1);
        chk("full_5th_id", s_aw_id, 5'h01);
        m0_w_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_drain", m0_w_ready, 1);
            tick;
        end
        chk("full_drained", s_w_valid, 0);
        m0_w_valid = 0; m0_w_last = 0;

        // downstream stall
        s_ar_ready = 0;
        m0_ar_valid = 1; m0_ar_id = 4'd1; m0_ar_addr = 32'h100;
        m1_ar_valid = 1; m1_ar_id = 4'd2; m1_ar_addr = 32'h200;
        #1;
        chk("st_m0_first", m0_ar_ready, 1);
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("st_s_id", s_ar_id, 5'h01);
            chk("st_s_addr", s_ar_addr, 32'h100);
            chk("st_m0_ready", m0_ar_ready, 0);
            chk("st_m1_ready", m1_ar_ready, 0);
            tick;
        end
        s_ar_ready = 1;
        #1;
        chk("st_rel_m1", m1_ar_ready, 1);
        chk("st_rel_m0", m0_ar_ready, 0);
        tick;
        m1_ar_valid = 0;
        #1;
        chk("st_s_id_m1", s_ar_id, 5'h12);
        chk("st_m0_next", m0_ar_ready, 1);
        tick;
        m0_ar_valid = 0;
        #1;
        chk("st_s_id_m0", s_ar_id, 5'h01);
        tick;
        chk("st_idle", s_ar_valid, 0);

        // reset mid-burst
        m0_aw_valid = 1; m0_aw_len = 8'd3; m0_aw_id = 4'd6;
        tick;
        m0_aw_valid = 0;
        m0_w_valid = 1; m0_w_data = 64'hD0; m0_w_last = 0;
        #1;
        chk("rb_beat1", m0_w_ready, 1);
        tick;
        m0_w_data = 64'hD1;
        reset = 1;
        #1;
        chk("rb_rst_w_ready", m0_w_ready, 0);
        chk("rb_rst_s_w_valid", s_w_valid, 0);
        tick;
        reset = 0;
        #1;
        chk("rb_s_aw_valid", s_aw_valid, 0);
        chk("rb_s_ar_valid", s_ar_valid, 0);
        chk("rb_fifo_empty", s_w_valid, 0);
        chk("rb_fifo_ready", m0_w_ready, 0);
        m0_w_valid = 0;
        m0_ar_valid = 1; m0_ar_id = 4'd5;
        m1_ar_valid = 1; m1_ar_id = 4'd9;
        #1;
        chk("rb_m0_wins", m0_ar_ready, 1);
        chk("rb_m1_waits", m1_ar_ready, 0);
        tick;
        m0_ar_valid = 0;
        #1;
        chk("rb_s_id_m0", s_ar_id, 5'h05);
        tick;
        m1_ar_valid = 0;
        #1;
        chk("rb_s_id_m1", s_ar_id, 5'h19);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
